bus_owner_arbiter: RTL and testbench
====================================

Name: bus_owner_arbiter

Overview:
- Upstream control stage for the shared tri-state output driver, which drives f from x when s=0 and from y when s=1.
- Arbitrates between two requesters, A (drives x) and B (drives y), and produces the registered select s, a bus output-enable oe and per-requester grants.
- Round-robin fairness, a bounded hold time per grant, and a mandatory idle turnaround between owners so the shared line is never driven by two owners back-to-back.

Parameters:
- MAX_HOLD, 8, max consecutive cycles one owner may hold the bus (>=1); reaching it forces release.
- TURN_CYCLES, 1, idle cycles (oe=0) inserted after every release (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_a  input  1  requester A wants the bus; level, held while it needs it.
- req_b  input  1  requester B wants the bus; level.
- gnt_a  output  1  A owns the bus this cycle (registered).
- gnt_b  output  1  B owns the bus this cycle (registered).
- s  output  1  select to the tri-state stage: 0 = A/x, 1 = B/y (registered).
- oe  output  1  bus drive enable; 1 only while a grant is active (registered).
- timeout  output  1  one-cycle pulse on a forced release at MAX_HOLD.
- owner_last  output  1  last granted owner: 0 = A, 1 = B. Used for round-robin and debug.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; gnt_a=0, gnt_b=0, oe=0, s=0, timeout=0, owner_last=1 (so A wins the first tie); hold_cnt=0, turn_cnt=0. Reset asserted mid-grant or mid-turn takes effect at that edge; no partial state survives.
- States: IDLE, GRANT_A, GRANT_B, TURN. All outputs are registered from the state and counters.
- IDLE:
  - req_a & req_b -> grant the requester != owner_last.
  - Only one request -> grant that one.
  - Neither -> stay in IDLE.
  - The grant appears at the edge where the request is sampled (latency 1 cycle from req high to gnt high).
- GRANT_x:
  - gnt_x=1, oe=1; s=0 for A, 1 for B; owner_last updated to x on entry; hold_cnt counts 0..MAX_HOLD-1 from the first grant cycle.
  - Voluntary release: req_x sampled 0 at an edge -> TURN at that edge, timeout=0.
  - Forced release: req_x still 1 and hold_cnt==MAX_HOLD-1 -> TURN, with timeout=1 during the first TURN cycle only.
  - Gnt therefore lasts at most MAX_HOLD cycles.
- TURN:
  - gnt_a=gnt_b=0, oe=0; s holds its previous value (no glitch on select while the bus is undriven).
  - turn_cnt counts 0..TURN_CYCLES-1.
  - On the edge where turn_cnt==TURN_CYCLES-1, apply the IDLE arbitration directly, so the next grant starts with no extra IDLE cycle. If there are no requests, go to IDLE.
- Round-robin: on a tie, the last owner loses. A lone requester is re-granted even if it was the last owner, including after a forced release, but always after a full TURN.
- Invariants, every cycle:
  - never gnt_a & gnt_b;
  - oe == gnt_a | gnt_b;
  - s==0 whenever gnt_a; s==1 whenever gnt_b;
  - oe=0 for at least TURN_CYCLES cycles between any two grants.
- Requests that drop in IDLE or TURN before they are sampled are ignored; there is no request memory.
- Counter widths: $clog2(MAX_HOLD+1) and $clog2(TURN_CYCLES+1); no wrap-around reachable.

Test Plan (MAX_HOLD=4, TURN_CYCLES=1 unless noted):
- Reset: hold rst_n=0 for 2 edges with req_a=req_b=1 -> all outputs 0, owner_last=1. Release reset -> gnt_a=1, s=0, oe=1 one edge later.
- Voluntary release: req_a high for 2 cycles then low -> gnt_a high exactly 2 cycles; next cycle oe=0, timeout=0; then IDLE with all outputs 0.
- Forced release with contention: req_a=req_b=1 held constant -> A holds 4 cycles, 1 turn cycle with timeout=1, then B holds 4 cycles with s=1, turn, then A. The cycle repeats with period 10 and the invariants are checked every cycle.
- Lone hog: only req_a=1 held, MAX_HOLD=2 -> repeating pattern gnt_a=1,1,0 with timeout pulsing on each 0 cycle; s stays 0 throughout.
- Turnaround length: TURN_CYCLES=3, A releases while req_b=1 -> oe=0 for exactly 3 cycles, s unchanged during the turn, then gnt_b=1 and s=1 on the same edge.
- Reset mid-grant: rst_n=0 for one edge during cycle 2 of a gnt_b grant -> next cycle gnt_b=0, oe=0, owner_last=1. Then with both requesting, A is granted first.

Source files
------------

// File: rtl/bus_owner_arbiter.sv
// Two-requester bus owner arbiter for a shared tri-state driver: round-robin on ties,
// bounded hold per grant, and an idle turnaround between owners.
module bus_owner_arbiter #(
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic s,
  output logic oe,
  output logic timeout,
  output logic owner_last
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    TURN    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  state_t        arb_s;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;
  logic          owner_last_q, owner_last_d;
  logic          s_q, s_d;
  logic          timeout_q, timeout_d;
  logic          gnt_a_q, gnt_b_q, oe_q;
  logic          gnt_a_d, gnt_b_d, oe_d;

  // On a tie the last owner loses; a lone requester always wins.
  always_comb begin
    arb_s = IDLE;
    if (req_a && (!req_b || owner_last_q)) begin
      arb_s = GRANT_A;
    end else if (req_b) begin
      arb_s = GRANT_B;
    end else begin
      arb_s = IDLE;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    owner_last_d = owner_last_q;
    s_d          = s_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = arb_s;
      end
      GRANT_A: begin
        if (!req_a) begin
          state_d    = TURN;
          turn_cnt_d = {TW{1'b0}};
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = TURN;
          turn_cnt_d = {TW{1'b0}};
          timeout_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          state_d    = TURN;
          turn_cnt_d = {TW{1'b0}};
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = TURN;
          turn_cnt_d = {TW{1'b0}};
          timeout_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d = arb_s;
        end else begin
          turn_cnt_d = turn_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Only IDLE and TURN can enter a grant, so entry always restarts the hold count.
    if (state_d == GRANT_A && state_q != GRANT_A) begin
      hold_cnt_d   = {HW{1'b0}};
      owner_last_d = 1'b0;
      s_d          = 1'b0;
    end else if (state_d == GRANT_B && state_q != GRANT_B) begin
      hold_cnt_d   = {HW{1'b0}};
      owner_last_d = 1'b1;
      s_d          = 1'b1;
    end else begin
      hold_cnt_d = hold_cnt_d;
    end

    gnt_a_d = (state_d == GRANT_A);
    gnt_b_d = (state_d == GRANT_B);
    oe_d    = gnt_a_d | gnt_b_d;
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= {HW{1'b0}};
      turn_cnt_q   <= {TW{1'b0}};
      owner_last_q <= 1'b1;
      s_q          <= 1'b0;
      timeout_q    <= 1'b0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      owner_last_q <= owner_last_d;
      s_q          <= s_d;
      timeout_q    <= timeout_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      oe_q         <= oe_d;
    end
  end

  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign s          = s_q;
  assign oe         = oe_q;
  assign timeout    = timeout_q;
  assign owner_last = owner_last_q;

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Directed bench: table-driven vectors on the MAX_HOLD=4/TURN=1 arbiter, plus
// hand sequences for MAX_HOLD=2 (lone hog) and TURN_CYCLES=3 (turnaround).
module tb_bus_owner_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic started = 1'b0;

  logic r0_n = 1'b0, a0 = 1'b0, b0 = 1'b0;
  logic ga0, gb0, s0, oe0, to0, ol0;
  logic r1_n = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic ga1, gb1, s1, oe1, to1, ol1;
  logic r2_n = 1'b0, a2 = 1'b0, b2 = 1'b0;
  logic ga2, gb2, s2, oe2, to2, ol2;

  bus_owner_arbiter #(.MAX_HOLD(4), .TURN_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(r0_n), .req_a(a0), .req_b(b0),
    .gnt_a(ga0), .gnt_b(gb0), .s(s0), .oe(oe0), .timeout(to0), .owner_last(ol0));
  bus_owner_arbiter #(.MAX_HOLD(2), .TURN_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(r1_n), .req_a(a1), .req_b(b1),
    .gnt_a(ga1), .gnt_b(gb1), .s(s1), .oe(oe1), .timeout(to1), .owner_last(ol1));
  bus_owner_arbiter #(.MAX_HOLD(4), .TURN_CYCLES(3)) u_dut2 (
    .clk(clk), .rst_n(r2_n), .req_a(a2), .req_b(b2),
    .gnt_a(ga2), .gnt_b(gb2), .s(s2), .oe(oe2), .timeout(to2), .owner_last(ol2));

  typedef struct packed {
    logic rst_n, req_a, req_b;
    logic gnt_a, gnt_b, s, oe, timeout, owner_last;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rn, input logic ra, input logic rb,
                              input logic ega, input logic egb, input logic es,
                              input logic eoe, input logic eto, input logic eol);
    vec_t v;
    v = '{rn, ra, rb, ega, egb, es, eoe, eto, eol};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic inv(input string name, input logic ga, input logic gb,
                     input logic sv, input logic oev);
    chk({name, "_mutex"}, ga & gb, 1'b0);
    chk({name, "_oe"}, oev, ga | gb);
    if (ga) chk({name, "_s_a"}, sv, 1'b0);
    if (gb) chk({name, "_s_b"}, sv, 1'b1);
  endtask

  // Invariants on every instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      inv("inv0", ga0, gb0, s0, oe0);
      inv("inv1", ga1, gb1, s1, oe1);
      inv("inv2", ga2, gb2, s2, oe2);
    end
  end

  initial begin
    // Reset held two edges with both requesting.
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Release reset; A takes the bus, holds 2 cycles, releases voluntarily.
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Contention from IDLE with owner_last=A: B first, period 10.
    for (int k = 0; k < 25; k++) begin
      case (k % 10)
        0, 1, 2, 3: add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        4:          add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        5, 6, 7, 8: add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        default:    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      endcase
    end
    // Lone B grant straight out of TURN, reset during its second cycle, then A wins tie.
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    @(posedge clk);
    #1 started = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      r0_n = vecs[i].rst_n;
      a0   = vecs[i].req_a;
      b0   = vecs[i].req_b;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_gnt_a", i), ga0, vecs[i].gnt_a);
      chk($sformatf("v%0d_gnt_b", i), gb0, vecs[i].gnt_b);
      chk($sformatf("v%0d_s", i), s0, vecs[i].s);
      chk($sformatf("v%0d_oe", i), oe0, vecs[i].oe);
      chk($sformatf("v%0d_timeout", i), to0, vecs[i].timeout);
      chk($sformatf("v%0d_owner_last", i), ol0, vecs[i].owner_last);
    end

    // Lone hog with MAX_HOLD=2: gnt_a 1,1,0 repeating, timeout on each 0.
    @(negedge clk);
    r1_n = 1'b0;
    a1   = 1'b1;
    @(negedge clk);
    r1_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hog%0d_gnt_a", k), ga1, (k % 3) != 2);
      chk($sformatf("hog%0d_timeout", k), to1, (k % 3) == 2);
      chk($sformatf("hog%0d_s", k), s1, 1'b0);
    end

    // TURN_CYCLES=3: A releases with B waiting.
    @(negedge clk);
    r2_n = 1'b0;
    @(negedge clk);
    r2_n = 1'b1;
    a2   = 1'b1;
    @(posedge clk);
    #1 chk("turn_gnt_a", ga2, 1'b1);
    @(negedge clk);
    a2 = 1'b0;
    b2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("turn%0d_oe", k), oe2, 1'b0);
      chk($sformatf("turn%0d_s", k), s2, 1'b0);
      chk($sformatf("turn%0d_gnt_b", k), gb2, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("turn_end_gnt_b", gb2, 1'b1);
    chk("turn_end_s", s2, 1'b1);
    chk("turn_end_oe", oe2, 1'b1);

    @(negedge clk);
    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
